// File: rtl/game_pkg.sv
// game_pkg: shared direction codes, round FSM states and pattern ROM for the memory game.
package game_pkg;
    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;
    localparam logic [1:0] GAME_STATE = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOW  = 3'd1,
        S_INPUT = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } phase_t;
    localparam logic [1:0] PATTERN [4][4] = '{
        '{DIR_L, DIR_U, DIR_D, DIR_D},
        '{DIR_R, DIR_R, DIR_L, DIR_U},
        '{DIR_U, DIR_D, DIR_L, DIR_R},
        '{DIR_D, DIR_L, DIR_U, DIR_R}
    };
    // Patterns longer than the ROM repeat from the first move.
    function automatic logic [1:0] pat_dir(input logic [1:0] sel, input int idx);
        return PATTERN[sel][2'(idx)];
    endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer followed by a one-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr <= '0;
        else sr <= {sr[1:0], d};
    assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: plays a stored pattern, collects player moves and holds a win/lose verdict.
module round_sequencer
    import game_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int RESULT_TICKS = 3,
    parameter logic [1:0] GAME_STATE = game_pkg::GAME_STATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [1:0] random,
    input  logic       step_en,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnM,
    output logic [2:0] phase,
    output logic [1:0] show_dir,
    output logic       show_valid,
    output logic [2:0] entry_cnt,
    output logic       win,
    output logic       lose
);
    localparam int TW = $clog2(RESULT_TICKS + 1);
    logic [4:0] raw, e;
    phase_t p;
    logic [1:0] sel;
    logic [2:0] idx;
    logic [1:0] moves [8];
    logic ovf, match;
    logic [TW-1:0] ticks;
    assign raw = {btnM, btnD, btnU, btnR, btnL};
    genvar i;
    for (i = 0; i < 5; i++) begin : g_btn
        btn_edge u_edge (.clk(clk), .rst(rst), .d(raw[i]), .pulse(e[i]));
    end
    wire dir_any = |e[3:0];
    wire [1:0] dir = e[0] ? DIR_L : e[1] ? DIR_R : e[2] ? DIR_U : DIR_D;
    wire full = entry_cnt == 3'(PAT_LEN);
    wire last = idx == 3'(PAT_LEN - 1);
    wire tick_done = ticks == TW'(RESULT_TICKS - 1);
    wire abort = p != S_IDLE && state != GAME_STATE;
    always_comb begin
        match = 1'b1;
        for (int k = 0; k < PAT_LEN; k++)
            if (moves[k] != pat_dir(sel, k)) match = 1'b0;
    end
    assign phase = p;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= S_IDLE; sel <= '0; idx <= '0; ovf <= 1'b0; ticks <= '0; entry_cnt <= '0;
            show_dir <= '0; show_valid <= 1'b0; win <= 1'b0; lose <= 1'b0;
            for (int k = 0; k < 8; k++) moves[k] <= '0;
        end else if (abort) begin
            p <= S_IDLE; sel <= '0; idx <= '0; ovf <= 1'b0; ticks <= '0; entry_cnt <= '0;
            show_dir <= '0; show_valid <= 1'b0; win <= 1'b0; lose <= 1'b0;
            for (int k = 0; k < 8; k++) moves[k] <= '0;
        end else begin
            // Verdict outputs trail the result phase by one cycle.
            win <= p == S_WIN;
            lose <= p == S_LOSE;
            case (p)
                S_IDLE:
                    if (state == GAME_STATE) begin
                        p <= S_SHOW; sel <= random; idx <= '0; entry_cnt <= '0; ovf <= 1'b0;
                        for (int k = 0; k < 8; k++) moves[k] <= '0;
                        show_valid <= 1'b1;
                        show_dir <= pat_dir(random, 0);
                    end
                S_SHOW:
                    if (step_en) begin
                        if (last) begin
                            p <= S_INPUT; show_valid <= 1'b0; show_dir <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                            show_dir <= pat_dir(sel, int'(idx) + 1);
                        end
                    end
                S_INPUT: begin
                    if (dir_any) begin
                        if (full) ovf <= 1'b1;
                        else begin
                            moves[entry_cnt] <= dir;
                            entry_cnt <= entry_cnt + 3'd1;
                        end
                    end
                    if (e[4]) p <= S_CHECK;
                end
                S_CHECK: begin
                    p <= (full && !ovf && match) ? S_WIN : S_LOSE;
                    ticks <= '0;
                end
                default:
                    if (step_en) begin
                        if (tick_done) p <= S_IDLE;
                        else ticks <= ticks + TW'(1);
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed rounds with random patterns/moves checked against a move-list model.
module tb_round_sequencer;
    logic clk = 1'b0, rst = 1'b0, step_en = 1'b0;
    logic btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnM = 1'b0;
    logic [1:0] state = 2'b00, random = 2'b00;
    logic [2:0] phase, entry_cnt;
    logic [1:0] show_dir;
    logic show_valid, win, lose;
    int checks = 0, failures = 0;
    int pat [4][4] = '{'{0, 2, 3, 3}, '{1, 1, 0, 2}, '{2, 3, 0, 1}, '{3, 0, 2, 1}};
    int ent [$];
    bit ovf;
    int cur_sel;

    round_sequencer dut (
        .clk(clk), .rst(rst), .state(state), .random(random), .step_en(step_en),
        .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD), .btnM(btnM),
        .phase(phase), .show_dir(show_dir), .show_valid(show_valid),
        .entry_cnt(entry_cnt), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btnL = v;
            1: btnR = v;
            2: btnU = v;
            3: btnD = v;
            default: btnM = v;
        endcase
    endtask

    task automatic model_press(input int d);
        if (ent.size() < 4) ent.push_back(d);
        else ovf = 1'b1;
    endtask

    function automatic bit exp_win();
        if (ovf || ent.size() != 4) return 1'b0;
        for (int k = 0; k < 4; k++) if (ent[k] != pat[cur_sel][k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_phase(input int p, input string tag);
        int n = 0;
        while (phase !== 3'(p) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(phase), 32'(p));
    endtask

    task automatic press(input int b, input bit live);
        chk("pre_edge_cnt", 32'(entry_cnt), 32'(ent.size()));
        set_btn(b, 1'b1);
        cyc(2);
        chk("sync_delay_cnt", 32'(entry_cnt), 32'(ent.size()));
        cyc(1);
        if (live && b < 4) model_press(b);
        chk("press_cnt", 32'(entry_cnt), 32'(ent.size()));
        set_btn(b, 1'b0);
        cyc(3);
    endtask

    task automatic do_show(input bit poke);
        wait_phase(1, "enter_show");
        ent.delete();
        ovf = 1'b0;
        chk("show_cnt0", 32'(entry_cnt), 0);
        chk("show_win0", 32'(win), 0);
        chk("show_lose0", 32'(lose), 0);
        for (int k = 0; k < 4; k++) begin
            chk("show_valid", 32'(show_valid), 1);
            chk("show_dir", 32'(show_dir), 32'(pat[cur_sel][k]));
            if (poke && k == 1) begin
                press(int'($urandom_range(0, 3)), 1'b0);
                press(4, 1'b0);
                chk("show_no_submit", 32'(phase), 1);
            end
            cyc(int'($urandom_range(0, 5)));
            tick();
        end
        chk("to_input", 32'(phase), 2);
        chk("input_valid0", 32'(show_valid), 0);
        chk("input_dir0", 32'(show_dir), 0);
    endtask

    task automatic finish_verdict(input bit hold_m, input int next_sel);
        bit w = exp_win();
        set_btn(4, 1'b1);
        cyc(4);
        chk("verdict_early_win", 32'(win), 0);
        chk("verdict_early_lose", 32'(lose), 0);
        chk("result_phase", 32'(phase), w ? 32'd4 : 32'd5);
        cyc(1);
        chk("win", 32'(win), 32'(w));
        chk("lose", 32'(lose), 32'(!w));
        set_btn(4, 1'b0);
        for (int t = 0; t < 3; t++) begin
            cyc(int'($urandom_range(1, 4)));
            chk("hold_win", 32'(win), 32'(w));
            chk("hold_lose", 32'(lose), 32'(!w));
            if (t == 2) begin
                random = 2'(next_sel);
                cur_sel = next_sel;
                if (hold_m) set_btn(4, 1'b1);
            end
            tick();
        end
        chk("back_idle", 32'(phase), 0);
        cyc(1);
        chk("replay_show", 32'(phase), 1);
        chk("replay_win0", 32'(win), 0);
        chk("replay_lose0", 32'(lose), 0);
    endtask

    initial begin
        cyc(3);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_dir", 32'(show_dir), 0);
        chk("rst_valid", 32'(show_valid), 0);
        chk("rst_cnt", 32'(entry_cnt), 0);
        chk("rst_win", 32'(win), 0);
        chk("rst_lose", 32'(lose), 0);
        rst = 1'b1;
        cyc(2);
        chk("idle_hold", 32'(phase), 0);
        // Round A: correct pattern 0.
        random = 2'd0;
        cur_sel = 0;
        state = 2'b10;
        do_show(1'b0);
        for (int k = 0; k < 4; k++) press(pat[cur_sel][k], 1'b1);
        chk("full_cnt", 32'(entry_cnt), 4);
        finish_verdict(1'b0, int'($urandom_range(0, 3)));
        // Round B: presses during SHOW, wrong last move.
        do_show(1'b1);
        for (int k = 0; k < 3; k++) press(pat[cur_sel][k], 1'b1);
        press(pat[cur_sel][3] ^ 1, 1'b1);
        finish_verdict(1'b0, int'($urandom_range(0, 3)));
        // Round C: five presses overflow.
        do_show(1'b0);
        for (int k = 0; k < 5; k++) press(int'($urandom_range(0, 3)), 1'b1);
        chk("sat_cnt", 32'(entry_cnt), 4);
        finish_verdict(1'b0, int'($urandom_range(0, 3)));
        // Round D: three presses, btnM held into the next round.
        do_show(1'b0);
        for (int k = 0; k < 3; k++) press(pat[cur_sel][k], 1'b1);
        finish_verdict(1'b1, int'($urandom_range(0, 3)));
        // Round E: held btnM, simultaneous L and D.
        do_show(1'b0);
        cyc(6);
        chk("held_m_no_submit", 32'(phase), 2);
        set_btn(4, 1'b0);
        cyc(3);
        btnL = 1'b1;
        btnD = 1'b1;
        cyc(3);
        model_press(0);
        chk("simul_cnt", 32'(entry_cnt), 1);
        btnL = 1'b0;
        btnD = 1'b0;
        cyc(3);
        chk("simul_cnt_stable", 32'(entry_cnt), 1);
        for (int k = 1; k < 4; k++) press(pat[cur_sel][k], 1'b1);
        finish_verdict(1'b0, int'($urandom_range(0, 3)));
        // Round F: leave gameplay during INPUT.
        do_show(1'b0);
        press(int'($urandom_range(0, 3)), 1'b1);
        state = 2'b00;
        cyc(1);
        chk("exit_phase", 32'(phase), 0);
        chk("exit_cnt", 32'(entry_cnt), 0);
        chk("exit_valid", 32'(show_valid), 0);
        chk("exit_win", 32'(win), 0);
        chk("exit_lose", 32'(lose), 0);
        cyc(3);
        chk("exit_stay_idle", 32'(phase), 0);
        // Round G: step_en on entry is ignored, then reset mid-SHOW.
        cur_sel = int'($urandom_range(0, 3));
        random = 2'(cur_sel);
        state = 2'b10;
        step_en = 1'b1;
        cyc(1);
        step_en = 1'b0;
        chk("entry_phase", 32'(phase), 1);
        chk("entry_step_ignored", 32'(show_dir), 32'(pat[cur_sel][0]));
        tick();
        chk("second_dir", 32'(show_dir), 32'(pat[cur_sel][1]));
        rst = 1'b0;
        #1;
        chk("mid_rst_phase", 32'(phase), 0);
        chk("mid_rst_dir", 32'(show_dir), 0);
        chk("mid_rst_valid", 32'(show_valid), 0);
        chk("mid_rst_cnt", 32'(entry_cnt), 0);
        chk("mid_rst_win", 32'(win), 0);
        chk("mid_rst_lose", 32'(lose), 0);
        cyc(2);
        state = 2'b00;
        rst = 1'b1;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
